// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer controller.
// Handles keypad entry of an M:SS time and counts it down on a 1 Hz tick
// using a mod-10 / mod-6 / mod-10 digit chain. It also drives the magnetron
// enable and a done indicator that clears itself after DONE_TICKS ticks.
module cook_timer_ctrl #(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       keypad_valid,
  input  logic [3:0] keypad_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       tick,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       mag_on,
  output logic       done,
  output logic       entry_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // The last done-tick count before returning to IDLE. The value is clamped
  // into the legal 1..15 range so that a bad override cannot wrap the counter.
  localparam int unsigned DONE_CLAMP = (DONE_TICKS < 32'd1)  ? 32'd1  :
                                       (DONE_TICKS > 32'd15) ? 32'd15 : DONE_TICKS;
  localparam logic [3:0]  DONE_LAST  = 4'(DONE_CLAMP - 32'd1);

  state_e     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       mag_q, mag_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       time_zero_s;
  logic       time_one_s;
  logic       keypad_ok_s;
  logic [3:0] dec_min_s;
  logic [3:0] dec_tens_s;
  logic [3:0] dec_units_s;

  // Flags derived from the current display digits and the keypad input.
  always_comb begin
    time_zero_s = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd0);
    time_one_s  = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd1);
    keypad_ok_s = keypad_valid && (keypad_digit <= 4'd9);
  end

  // One-second decrement of the digit chain. Borrows ripple from units into
  // tens and from tens into minutes. The value 0:00 is never decremented, so
  // the minutes digit is never borrowed from at zero.
  always_comb begin
    dec_min_s   = min_q;
    dec_tens_s  = tens_q;
    dec_units_s = units_q;
    if (units_q != 4'd0) begin
      dec_units_s = units_q - 4'd1;
    end else begin
      dec_units_s = 4'd9;
      if (tens_q != 4'd0) begin
        dec_tens_s = tens_q - 4'd1;
      end else begin
        dec_tens_s = 4'd5;
        if (min_q != 4'd0) begin
          dec_min_s = min_q - 4'd1;
        end else begin
          dec_min_s = 4'd0;
        end
      end
    end
  end

  // Next-state logic. Within each state the inputs are applied in the order
  // door open > stop > start > tick > keypad; clr is handled in the flops.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    units_d = units_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          min_d   = 4'd0;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end else if (start) begin
          if (!door_closed || time_zero_s || (tens_q > 4'd5)) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (keypad_ok_s) begin
          min_d   = tens_q;
          tens_d  = units_q;
          units_d = keypad_digit;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!door_closed || stop) begin
          state_d = ST_PAUSED;
        end else if (time_zero_s) begin
          // Cannot normally happen; finish instead of wrapping to 9:59.
          state_d = ST_DONE;
          dcnt_d  = 4'd0;
        end else if (tick) begin
          min_d   = dec_min_s;
          tens_d  = dec_tens_s;
          units_d = dec_units_s;
          if (time_one_s) begin
            state_d = ST_DONE;
            dcnt_d  = 4'd0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          state_d = ST_IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          units_d = 4'd0;
        end else if (start && door_closed) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_DONE: begin
        if (!door_closed || stop) begin
          state_d = ST_IDLE;
          dcnt_d  = 4'd0;
        end else if (tick) begin
          if (dcnt_q >= DONE_LAST) begin
            state_d = ST_IDLE;
            dcnt_d  = 4'd0;
          end else begin
            dcnt_d  = dcnt_q + 4'd1;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        min_d   = 4'd0;
        tens_d  = 4'd0;
        units_d = 4'd0;
        dcnt_d  = 4'd0;
      end
    endcase
    mag_d  = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, digit and output registers with a synchronous clear.
  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= ST_IDLE;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      dcnt_q  <= 4'd0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      dcnt_q  <= dcnt_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign min_units = min_q;
  assign sec_tens  = tens_q;
  assign sec_units = units_q;
  assign mag_on    = mag_q;
  assign done      = done_q;
  assign entry_err = err_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed testbench for cook_timer_ctrl. Each step pushes its expected
// {min,tens,units,mag_on,done,entry_err} onto a queue. After the clock edge
// the step pops that entry and compares it with the observed outputs.
module tb_cook_timer_ctrl;

  logic       clock;
  logic       clr;
  logic       keypad_valid;
  logic [3:0] keypad_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       tick;
  logic [3:0] min_units;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;
  logic       mag_on;
  logic       done;
  logic       entry_err;

  int         vectors;
  int         miscompares;
  logic [14:0] exp_q[$];

  cook_timer_ctrl #(.DONE_TICKS(3)) dut (
    .clock        (clock),
    .clr          (clr),
    .keypad_valid (keypad_valid),
    .keypad_digit (keypad_digit),
    .start        (start),
    .stop         (stop),
    .door_closed  (door_closed),
    .tick         (tick),
    .min_units    (min_units),
    .sec_tens     (sec_tens),
    .sec_units    (sec_units),
    .mag_on       (mag_on),
    .done         (done),
    .entry_err    (entry_err)
  );

  always #5 clock = ~clock;

  function automatic logic [14:0] ex(input logic [3:0] m, input logic [3:0] t,
                                     input logic [3:0] u, input logic mg,
                                     input logic dn, input logic er);
    return {m, t, u, mg, dn, er};
  endfunction

  // Drive one cycle of inputs, queue its expectation, then check after the edge.
  task automatic step(input string tag, input logic kv, input logic [3:0] kd,
                      input logic st, input logic sp, input logic dr,
                      input logic tk, input logic cl, input logic [14:0] expv);
    logic [14:0] obs;
    logic [14:0] want;
    keypad_valid = kv;
    keypad_digit = kd;
    start        = st;
    stop         = sp;
    door_closed  = dr;
    tick         = tk;
    clr          = cl;
    exp_q.push_back(expv);
    @(posedge clock);
    #1;
    keypad_valid = 1'b0;
    keypad_digit = 4'd0;
    start        = 1'b0;
    stop         = 1'b0;
    tick         = 1'b0;
    clr          = 1'b0;
    obs  = {min_units, sec_tens, sec_units, mag_on, done, entry_err};
    want = exp_q.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  initial begin
    clock = 1'b0; clr = 1'b0; keypad_valid = 1'b0; keypad_digit = 4'd0;
    start = 1'b0; stop = 1'b0; door_closed = 1'b1; tick = 1'b0;
    vectors = 0; miscompares = 0;
    #2;
    // Reset and entry
    step("rst1",   0, 4'd0,  0, 0, 1, 0, 1, ex(0, 0, 0, 0, 0, 0));
    step("rst2",   0, 4'd0,  0, 0, 1, 1, 1, ex(0, 0, 0, 0, 0, 0));
    step("key1",   1, 4'd1,  0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0));
    step("key3",   1, 4'd3,  0, 0, 1, 0, 0, ex(0, 1, 3, 0, 0, 0));
    step("key0",   1, 4'd0,  0, 0, 1, 0, 0, ex(1, 3, 0, 0, 0, 0));
    step("key12",  1, 4'd12, 0, 0, 1, 0, 0, ex(1, 3, 0, 0, 0, 0));
    step("key5",   1, 4'd5,  0, 0, 1, 0, 0, ex(3, 0, 5, 0, 0, 0));
    step("idlclr", 0, 4'd0,  0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    // Borrow chain from 1:00
    step("k1",     1, 4'd1,  0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0));
    step("k0a",    1, 4'd0,  0, 0, 1, 0, 0, ex(0, 1, 0, 0, 0, 0));
    step("k0b",    1, 4'd0,  0, 0, 1, 0, 0, ex(1, 0, 0, 0, 0, 0));
    step("start",  0, 4'd0,  1, 0, 1, 0, 0, ex(1, 0, 0, 1, 0, 0));
    step("heldst", 0, 4'd0,  1, 0, 1, 0, 0, ex(1, 0, 0, 1, 0, 0));
    step("tick59", 0, 4'd0,  1, 0, 1, 1, 0, ex(0, 5, 9, 1, 0, 0));
    for (int s = 58; s >= 1; s--) begin
      step("cdown", 0, 4'd0, 0, 0, 1, 1, 0, ex(0, 4'(s / 10), 4'(s % 10), 1, 0, 0));
    end
    step("tick0",  0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 1, 0));
    // DONE timeout after three ticks; start and keypad are ignored
    step("dnidle", 0, 4'd0,  1, 0, 1, 0, 0, ex(0, 0, 0, 0, 1, 0));
    step("dnkey",  1, 4'd4,  0, 0, 1, 0, 0, ex(0, 0, 0, 0, 1, 0));
    step("dtk1",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 1, 0));
    step("dtk2",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 1, 0));
    step("dtk3",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 0, 0));
    // Repeat, then stop while in DONE
    step("r_k1",   1, 4'd1,  0, 0, 1, 0, 0, ex(0, 0, 1, 0, 0, 0));
    step("r_st",   0, 4'd0,  1, 0, 1, 0, 0, ex(0, 0, 1, 1, 0, 0));
    step("r_tk",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 1, 0));
    step("r_tk1",  0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 1, 0));
    step("r_stop", 0, 4'd0,  0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    // Start rejections
    step("rej0",   0, 4'd0,  1, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 1));
    step("rej0e",  0, 4'd0,  0, 0, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step("k7",     1, 4'd7,  0, 0, 1, 0, 0, ex(0, 0, 7, 0, 0, 0));
    step("k5",     1, 4'd5,  0, 0, 1, 0, 0, ex(0, 7, 5, 0, 0, 0));
    step("rej75",  0, 4'd0,  1, 0, 1, 0, 0, ex(0, 7, 5, 0, 0, 1));
    step("clr75",  0, 4'd0,  0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    step("k1b",    1, 4'd1,  0, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 0));
    step("k0c",    1, 4'd0,  0, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0));
    step("rejdr",  0, 4'd0,  1, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 1));
    step("rejdre", 0, 4'd0,  0, 0, 0, 0, 0, ex(0, 1, 0, 0, 0, 0));
    // Door and pause during RUN
    step("p_st",   0, 4'd0,  1, 0, 1, 0, 0, ex(0, 1, 0, 1, 0, 0));
    step("p_t9",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 9, 1, 0, 0));
    step("p_t8",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 8, 1, 0, 0));
    step("p_t7",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 7, 1, 0, 0));
    step("p_door", 0, 4'd0,  0, 0, 0, 1, 0, ex(0, 0, 7, 0, 0, 0));
    step("p_stop", 0, 4'd0,  1, 0, 0, 0, 0, ex(0, 0, 7, 0, 0, 0));
    step("p_tkig", 1, 4'd3,  0, 0, 1, 1, 0, ex(0, 0, 7, 0, 0, 0));
    step("p_res",  0, 4'd0,  1, 0, 1, 0, 0, ex(0, 0, 7, 1, 0, 0));
    step("p_t6",   0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 6, 1, 0, 0));
    step("p_sp1",  0, 4'd0,  0, 1, 1, 0, 0, ex(0, 0, 6, 0, 0, 0));
    step("p_sp2",  0, 4'd0,  0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    // Simultaneous stop and start in RUN
    step("s_k5",   1, 4'd5,  0, 0, 1, 0, 0, ex(0, 0, 5, 0, 0, 0));
    step("s_st",   0, 4'd0,  1, 0, 1, 0, 0, ex(0, 0, 5, 1, 0, 0));
    step("s_both", 0, 4'd0,  1, 1, 1, 1, 0, ex(0, 0, 5, 0, 0, 0));
    step("s_stop", 0, 4'd0,  0, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0));
    // Mid-run clr with tick
    step("m_k4",   1, 4'd4,  0, 0, 1, 0, 0, ex(0, 0, 4, 0, 0, 0));
    step("m_k2",   1, 4'd2,  0, 0, 1, 0, 0, ex(0, 4, 2, 0, 0, 0));
    step("m_st",   0, 4'd0,  1, 0, 1, 0, 0, ex(0, 4, 2, 1, 0, 0));
    step("m_clr",  0, 4'd0,  1, 0, 1, 1, 1, ex(0, 0, 0, 0, 0, 0));
    step("m_idle", 0, 4'd0,  0, 0, 1, 1, 0, ex(0, 0, 0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
